// File: rtl/run_length_detector_pkg.sv
// rtl/run_length_detector_pkg.sv - shared constants and helpers for the run-length detector
// Package rld_pkg: detection-mode encodings, run-counter width helper, and the
// mode/polarity match function. The optional detection counter is enabled by the
// RLD_DET_COUNT_EN macro in the files that use this package.
package rld_pkg;

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ONES  = 2'b01;
  localparam logic [1:0] MODE_ZEROS = 2'b10;
  localparam logic [1:0] MODE_BOTH  = 2'b11;

  // Bits needed to hold 0..run_len, i.e. $clog2(run_len+1).
  function automatic int cnt_width(input int run_len);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) <= run_len) w = i + 1;
    end
    return w;
  endfunction

  // True when a run of value b is of a polarity selected by mode.
  function automatic logic mode_match(input logic [1:0] mode, input logic b);
    logic m;
    case (mode)
      MODE_OFF:   m = 1'b0;
      MODE_ONES:  m = b;
      MODE_ZEROS: m = ~b;
      MODE_BOTH:  m = 1'b1;
      default:    m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/run_length_detector_if.sv
// rtl/run_length_detector_if.sv - sample/result signal bundle for the run-length detector
// Signals: en, clr, mode[1:0], w (driven by master); z, run_len[CNT_W-1:0]
// and, with RLD_DET_COUNT_EN defined, det_count[DET_W-1:0] (driven by slave).
interface run_length_detector_if #(
  parameter int RUN_LEN = 4
`ifdef RLD_DET_COUNT_EN
  , parameter int DET_W = 8
`endif
);
  import rld_pkg::*;

  localparam int CNT_W = cnt_width(RUN_LEN);

  logic             en;
  logic             clr;
  logic [1:0]       mode;
  logic             w;
  logic             z;
  logic [CNT_W-1:0] run_len;
`ifdef RLD_DET_COUNT_EN
  logic [DET_W-1:0] det_count;

  modport master (output en, clr, mode, w, input z, run_len, det_count);
  modport slave  (input en, clr, mode, w, output z, run_len, det_count);
`else
  modport master (output en, clr, mode, w, input z, run_len);
  modport slave  (input en, clr, mode, w, output z, run_len);
`endif

endinterface

// File: rtl/run_length_detector_run_counter.sv
// rtl/run_length_detector_run_counter.sv - saturating run counter with last-value tracking
// Ports: clk, rst_n (async active-low), en, clr, w in; cnt/last registered state,
// cnt_next/last_next the values being loaded this edge (used for a same-edge z).
module rld_run_counter #(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             w,
  output logic [CNT_W-1:0] cnt,
  output logic             last,
  output logic [CNT_W-1:0] cnt_next,
  output logic             last_next
);

  logic             have_prev_q, have_prev_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    have_prev_d = have_prev_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    if (clr) begin
      have_prev_d = 1'b0;
      last_d      = 1'b0;
      cnt_d       = '0;
    end else if (en) begin
      if (!have_prev_q || (w != last_q)) begin
        // First sample after reset/clear, or the run broke: start a new run.
        cnt_d       = CNT_W'(1);
        last_d      = w;
        have_prev_d = 1'b1;
      end else if (cnt_q != CNT_W'(RUN_LEN)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have_prev_q <= 1'b0;
      last_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      have_prev_q <= have_prev_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cnt       = cnt_q;
  assign last      = last_q;
  assign cnt_next  = cnt_d;
  assign last_next = last_d;

endmodule

// File: rtl/run_length_detector.sv
// rtl/run_length_detector.sv - detects RUN_LEN consecutive equal accepted samples of w
// Ports: Clock, Resetn (async active-low), bus (slave: en, clr, mode, w in;
// z, run_len out; det_count out when RLD_DET_COUNT_EN is defined).
module run_length_detector
  import rld_pkg::*;
#(
  parameter int RUN_LEN = 4
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  run_length_detector_if.slave bus
);

  localparam int CNT_W = cnt_width(RUN_LEN);

  logic [CNT_W-1:0] cnt;
  logic             last;
  logic [CNT_W-1:0] cnt_next;
  logic             last_next;
  logic             z_q, z_d;

  rld_run_counter #(
    .RUN_LEN (RUN_LEN),
    .CNT_W   (CNT_W)
  ) u_run_counter (
    .clk       (Clock),
    .rst_n     (Resetn),
    .en        (bus.en),
    .clr       (bus.clr),
    .w         (bus.w),
    .cnt       (cnt),
    .last      (last),
    .cnt_next  (cnt_next),
    .last_next (last_next)
  );

  // z is judged on the values being loaded, so it rises on the accepting edge.
  // mode only matters on accepted samples; otherwise z holds.
  always_comb begin
    z_d = z_q;
    if (bus.clr) begin
      z_d = 1'b0;
    end else if (bus.en) begin
      z_d = (cnt_next == CNT_W'(RUN_LEN)) && mode_match(bus.mode, last_next);
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) z_q <= 1'b0;
    else         z_q <= z_d;
  end

  assign bus.z       = z_q;
  assign bus.run_len = cnt;

`ifdef RLD_DET_COUNT_EN
  localparam int DET_W = $bits(bus.det_count);

  logic [DET_W-1:0] det_q, det_d;

  // Counts rising edges of z (new detections), saturating at all ones.
  always_comb begin
    det_d = det_q;
    if (bus.clr) begin
      det_d = '0;
    end else if (z_d && !z_q && (det_q != {DET_W{1'b1}})) begin
      det_d = det_q + DET_W'(1);
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) det_q <= '0;
    else         det_q <= det_d;
  end

  assign bus.det_count = det_q;
`else
  // last is only needed by the run counter itself in this build.
  logic unused_last;
  assign unused_last = last;
`endif

endmodule
